pulse_channel_2: RTL and testbench

- Game Boy APU pulse (square-wave) channel 2: duty-cycle waveform generator with length counter and volume envelope, no frequency sweep.
- Driven by the system clock plus level-type frame-sequencer timing signals (256/128/64 Hz) generated elsewhere.
- Produces a 4-bit digital amplitude for the mixer/DAC stage.

---
 rtl/pulse_channel_2.sv | 158 +++++++++++++++
 tb/tb_pulse_channel_2.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_channel_2.sv
// Game Boy APU pulse channel 2: duty-cycle square wave with a length counter and
// a volume envelope. There is no frequency sweep.
// Latency: amplitude is registered one clk after the internal state changes.
// Backpressure: none. Frame-sequencer timebases are levels and the channel acts
// on their rising edges.
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   clk_256 / clk_64    length / envelope timebases (rising edge = one tick)
//   clk_128             sweep timebase, accepted but unused by this channel
//   freq                11-bit frequency register value
//   length_load         length register value (length = 64 - length_load)
//   duty_cycle          selects the duty pattern
//   starting_volume     initial envelope volume
//   period              envelope period in 64 Hz ticks (0 = envelope frozen)
//   length_enable       allows the length counter to silence the channel
//   trigger             restarts the channel on its rising edge
//   env_add             envelope direction (1 = up, 0 = down)
//   amplitude           4-bit sample to the mixer
module pulse_channel_2 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_256,
  input  logic        clk_128,
  input  logic        clk_64,
  input  logic [10:0] freq,
  input  logic [5:0]  length_load,
  input  logic [1:0]  duty_cycle,
  input  logic [3:0]  starting_volume,
  input  logic [2:0]  period,
  input  logic        length_enable,
  input  logic        trigger,
  input  logic        env_add,
  output logic [3:0]  amplitude
);

  // This channel has no sweep unit, so the 128 Hz timebase is deliberately dropped.
  logic unused_clk_128;
  assign unused_clk_128 = clk_128;

  logic        enabled_q,    enabled_d;
  logic [3:0]  volume_q,     volume_d;
  logic [6:0]  length_q,     length_d;
  logic [13:0] freq_timer_q, freq_timer_d;
  logic [2:0]  duty_step_q,  duty_step_d;
  logic [2:0]  env_timer_q,  env_timer_d;
  logic        clk_256_q, clk_64_q, trigger_q;
  logic [3:0]  amplitude_q,  amplitude_d;

  logic        len_evt, env_evt, trig_evt;
  logic [13:0] reload_val;
  logic [7:0]  duty_pattern;
  logic        duty_bit;

  assign len_evt  = clk_256 & ~clk_256_q;
  assign env_evt  = clk_64  & ~clk_64_q;
  assign trig_evt = trigger & ~trigger_q;

  // (2048 - freq) * 4. The result is up to 8192, so it needs 14 bits.
  assign reload_val = {12'd2048 - {1'b0, freq}, 2'b00};

  // Bit n of the pattern is the output level for duty step n.
  always_comb begin
    duty_pattern = 8'b1000_0000;
    case (duty_cycle)
      2'b00: duty_pattern = 8'b1000_0000;
      2'b01: duty_pattern = 8'b1000_0001;
      2'b10: duty_pattern = 8'b1110_0001;
      2'b11: duty_pattern = 8'b0111_1110;
      default: duty_pattern = 8'b1000_0000;
    endcase
  end

  assign duty_bit = duty_pattern[duty_step_q];

  always_comb begin
    enabled_d    = enabled_q;
    volume_d     = volume_q;
    length_d     = length_q;
    freq_timer_d = freq_timer_q;
    duty_step_d  = duty_step_q;
    env_timer_d  = env_timer_q;

    // Reload on the cycle the timer would hit 0, so each duty step lasts exactly
    // reload_val clks. A new freq is only picked up here.
    if (enabled_q) begin
      if (freq_timer_q <= 14'd1) begin
        freq_timer_d = reload_val;
        duty_step_d  = duty_step_q + 3'd1;
      end else begin
        freq_timer_d = freq_timer_q - 14'd1;
      end
    end

    if (len_evt && length_enable && (length_q != 7'd0)) begin
      length_d = length_q - 7'd1;
      if (length_q == 7'd1) begin
        enabled_d = 1'b0;
      end
    end

    // The envelope timer also reloads on its last tick. Treating 0 the same as 1
    // covers a channel triggered with period 0 whose period is changed later.
    if (env_evt && (period != 3'd0)) begin
      if (env_timer_q <= 3'd1) begin
        env_timer_d = period;
        if (env_add) begin
          if (volume_q != 4'd15) volume_d = volume_q + 4'd1;
        end else begin
          if (volume_q != 4'd0) volume_d = volume_q - 4'd1;
        end
      end else begin
        env_timer_d = env_timer_q - 3'd1;
      end
    end

    // A trigger overrides every tick that lands in the same cycle.
    if (trig_evt) begin
      enabled_d    = (starting_volume != 4'd0) || env_add;  // DAC off -> stay silent
      freq_timer_d = reload_val;
      duty_step_d  = 3'd0;
      length_d     = 7'd64 - {1'b0, length_load};
      volume_d     = starting_volume;
      env_timer_d  = period;
    end
  end

  assign amplitude_d = (enabled_q && duty_bit) ? volume_q : 4'd0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enabled_q    <= 1'b0;
      volume_q     <= 4'd0;
      length_q     <= 7'd0;
      freq_timer_q <= 14'd0;
      duty_step_q  <= 3'd0;
      env_timer_q  <= 3'd0;
      clk_256_q    <= 1'b0;
      clk_64_q     <= 1'b0;
      trigger_q    <= 1'b0;
      amplitude_q  <= 4'd0;
    end else begin
      enabled_q    <= enabled_d;
      volume_q     <= volume_d;
      length_q     <= length_d;
      freq_timer_q <= freq_timer_d;
      duty_step_q  <= duty_step_d;
      env_timer_q  <= env_timer_d;
      clk_256_q    <= clk_256;
      clk_64_q     <= clk_64;
      trigger_q    <= trigger;
      amplitude_q  <= amplitude_d;
    end
  end

  assign amplitude = amplitude_q;

endmodule

// File: tb/tb_pulse_channel_2.sv
// Bench for pulse_channel_2: expected amplitudes are queued against the clk
// count at which they must appear, then popped and compared on the falling edge.
module tb_pulse_channel_2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clk_256 = 1'b0;
  logic        clk_128 = 1'b0;
  logic        clk_64 = 1'b0;
  logic [10:0] freq = 11'd0;
  logic [5:0]  length_load = 6'd0;
  logic [1:0]  duty_cycle = 2'd0;
  logic [3:0]  starting_volume = 4'd0;
  logic [2:0]  period = 3'd0;
  logic        length_enable = 1'b0;
  logic        trigger = 1'b0;
  logic        env_add = 1'b0;
  logic [3:0]  amplitude;

  pulse_channel_2 dut (
    .clk(clk), .reset_n(reset_n), .clk_256(clk_256), .clk_128(clk_128),
    .clk_64(clk_64), .freq(freq), .length_load(length_load),
    .duty_cycle(duty_cycle), .starting_volume(starting_volume),
    .period(period), .length_enable(length_enable), .trigger(trigger),
    .env_add(env_add), .amplitude(amplitude)
  );

  always #5 clk = ~clk;
  always #37 clk_128 = ~clk_128;  // free-running and unrelated to clk; it must not matter

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [3:0] amp;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic void push(input int at, input logic [3:0] amp, input string tag);
    exp_t e;
    e.at = at; e.amp = amp; e.tag = tag;
    exp_q.push_back(e);
  endfunction

  // Reference duty table: bit n is the level for step n.
  function automatic logic [3:0] exp_amp(input logic [1:0] d, input int step, input logic [3:0] vol);
    logic [7:0] pat;
    case (d)
      2'b00:   pat = 8'b1000_0000;
      2'b01:   pat = 8'b1000_0001;
      2'b10:   pat = 8'b1110_0001;
      default: pat = 8'b0111_1110;
    endcase
    return pat[step] ? vol : 4'd0;
  endfunction

  task automatic drain(input int budget);
    int   n;
    exp_t e;
    n = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      n++;
      if (cyc == exp_q[0].at) begin
        e = exp_q.pop_front();
        check_val(e.tag, amplitude, e.amp);
      end else if (cyc > exp_q[0].at) begin
        e = exp_q.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL %s: sample point cyc %0d missed (now %0d)", e.tag, e.at, cyc);
      end
      if (n > budget && exp_q.size() > 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL drain_timeout: %0d expectations left, budget %0d", exp_q.size(), budget);
        exp_q.delete();
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns the clk count of the edge that sees the trigger rising.
  task automatic fire(output int e);
    trigger = 1'b1;
    e = cyc + 1;
    tick();
    trigger = 1'b0;
    tick();
  endtask

  task automatic pulse_64();
    clk_64 = 1'b1; tick(); clk_64 = 1'b0; tick();
  endtask

  task automatic pulse_256();
    clk_256 = 1'b1; tick(); clk_256 = 1'b0; tick();
  endtask

  initial begin
    #(3_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int v;
    logic [1:0] duties [4];
    duties[0] = 2'b00; duties[1] = 2'b10; duties[2] = 2'b11; duties[3] = 2'b01;

    // Reset state
    #2 check_val("rst_init", amplitude, 4'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= 5; k++) push(cyc + k, 4'd0, $sformatf("idle_%0d", k));
    drain(20);

    // Full waveform, freq=1024: 4096 clks per step
    freq = 11'd1024; duty_cycle = 2'b01; starting_volume = 4'd15;
    period = 3'd0; length_enable = 1'b0; env_add = 1'b0;
    fire(e);
    for (int s = 0; s < 8; s++) begin
      push(e + s * 4096 + 1, exp_amp(2'b01, s, 4'd15), $sformatf("wave_s%0d_first", s));
      push(e + (s + 1) * 4096, exp_amp(2'b01, s, 4'd15), $sformatf("wave_s%0d_last", s));
    end
    push(e + 8 * 4096 + 1, 4'd15, "wave_wrap");
    drain(40000);

    // Asynchronous reset while the tone is high
    #1 reset_n = 1'b0;
    #1 check_val("rst_async", amplitude, 4'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= 20; k++) push(cyc + k, 4'd0, $sformatf("rst_hold_%0d", k));
    drain(40);

    // Duty sweep at freq=2047: 4 clks per step
    freq = 11'd2047;
    for (int i = 0; i < 4; i++) begin
      duty_cycle = duties[i];
      fire(e);
      for (int k = 1; k <= 33; k++)
        push(e + k, exp_amp(duties[i], ((k - 1) / 4) % 8, 4'd15),
             $sformatf("duty%0d_c%0d", duties[i], k));
      drain(60);
    end

    // Envelope down from 15, period 2 (step 0 of duty 10 is high for 8192 clks)
    freq = 11'd0; duty_cycle = 2'b10; starting_volume = 4'd15;
    period = 3'd2; env_add = 1'b0;
    fire(e);
    push(e + 1, 4'd15, "env_dn_start");
    drain(10);
    for (int i = 1; i <= 32; i++) begin
      pulse_64();
      v = 15 - i / 2;
      if (v < 0) v = 0;
      push(cyc, v[3:0], $sformatf("env_dn_%0d", i));
      drain(4);
    end

    // Envelope up from 14, saturating at 15
    starting_volume = 4'd14; env_add = 1'b1;
    fire(e);
    push(e + 1, 4'd14, "env_up_start");
    drain(10);
    for (int i = 1; i <= 6; i++) begin
      pulse_64();
      v = 14 + i / 2;
      if (v > 15) v = 15;
      push(cyc, v[3:0], $sformatf("env_up_%0d", i));
      drain(4);
    end

    // Length counter: 64-18 = 46 ticks
    starting_volume = 4'd15; env_add = 1'b0; period = 3'd0;
    length_load = 6'd18; length_enable = 1'b1;
    fire(e);
    for (int i = 1; i <= 46; i++) begin
      pulse_256();
      if (i == 1 || i == 45) begin
        push(cyc, 4'd15, $sformatf("len_%0d", i));
        drain(4);
      end else if (i == 46) begin
        push(cyc, 4'd0, "len_46");
        drain(4);
      end
    end

    // Length disabled: the tone keeps going
    length_enable = 1'b0;
    fire(e);
    for (int i = 1; i <= 100; i++) begin
      pulse_256();
      if (i == 46 || i == 100) begin
        push(cyc, 4'd15, $sformatf("len_off_%0d", i));
        drain(4);
      end
    end

    // Trigger on the same cycle as a clk_256 edge: no decrement that cycle
    length_enable = 1'b1;
    @(negedge clk);
    trigger = 1'b1; clk_256 = 1'b1;
    tick();
    trigger = 1'b0; clk_256 = 1'b0;
    tick();
    for (int i = 1; i <= 46; i++) begin
      pulse_256();
      if (i == 45) begin
        push(cyc, 4'd15, "coin_45");
        drain(4);
      end else if (i == 46) begin
        push(cyc, 4'd0, "coin_46");
        drain(4);
      end
    end

    // DAC off: the channel stays disabled even once the envelope raises the volume
    starting_volume = 4'd0; env_add = 1'b0; period = 3'd1; length_enable = 1'b0;
    fire(e);
    push(e + 1, 4'd0, "dac_off");
    push(e + 5, 4'd0, "dac_off_hold");
    drain(10);
    env_add = 1'b1;
    repeat (3) pulse_64();
    push(cyc, 4'd0, "dac_off_env");
    drain(4);

    // A normal trigger afterwards re-enables the channel
    starting_volume = 4'd5; env_add = 1'b0; period = 3'd0;
    fire(e);
    push(e + 1, 4'd5, "retrig");
    drain(10);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
